// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the decode/operand-fetch stage: data/address/
// instruction widths, opcode values, instruction field positions, FSM state
// encoding and small decode helpers.
package proc_isa_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;
    localparam int IW_DEF = 16;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions (imm6 overlaps rs2)
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CAPT  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;

    // Sign-extend the 6-bit immediate to the data width
    function automatic logic [DW_DEF-1:0] sext_imm6(input logic [5:0] imm);
        return {{(DW_DEF-6){imm[5]}}, imm};
    endfunction

    function automatic logic op_is_rtype(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic op_reads_rs1(input logic [3:0] op);
        return op_is_rtype(op) || (op == OP_ADDI);
    endfunction

    function automatic logic op_reads_rs2(input logic [3:0] op);
        return op_is_rtype(op);
    endfunction

    // Opcodes that travel down to the execute stage (all of them write rd)
    function automatic logic op_issues(input logic [3:0] op);
        return op_is_rtype(op) || (op == OP_ADDI) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard: one pending bit per register. Issue sets a bit,
// writeback clears one; a set on the same edge as a clear of the same
// register wins. Hazard output looks at the registered vector only.
module reg_scoreboard
    import proc_isa_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    input  logic [AW-1:0]        rs1_addr,
    input  logic                 rs1_need,
    input  logic [AW-1:0]        rs2_addr,
    input  logic                 rs2_need,
    output logic                 hazard,
    output logic [(1<<AW)-1:0]   busy_vec
);

    localparam int NR = 1 << AW;

    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_d;
    logic [NR-1:0] set_mask;
    logic [NR-1:0] clr_mask;

    // Next busy vector: clear first, then OR in the set so the set wins
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // RAW hazard on any needed source whose bit is pending
    always_comb begin
        hazard = (rs1_need && busy_q[rs1_addr]) || (rs2_need && busy_q[rs2_addr]);
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage in front of the 8x8 register file.
// Flow: IDLE (accept) -> CHECK (wait out RAW hazards) -> READ (rf enables)
// -> CAPT (rf data valid) -> ISSUE (hold bundle until out_ready).
// LDI jumps CHECK -> ISSUE. NOP/HALT/illegal are consumed in IDLE.
// Optional: define OPFETCH_ILLEGAL_TRAP_EN to add a sticky err output that
// blocks further accepts when an illegal opcode arrives.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer keeps valid and its payload stable until then.
module operand_fetch
    import proc_isa_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        in_instr,
    output logic [AW-1:0]        rf_rd_addr1,
    output logic [AW-1:0]        rf_rd_addr2,
    output logic                 rf_rd_en1,
    output logic                 rf_rd_en2,
    input  logic [DW-1:0]        rf_rd_data1,
    input  logic [DW-1:0]        rf_rd_data2,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_op,
    output logic [AW-1:0]        out_dst,
    output logic [DW-1:0]        out_a,
    output logic [DW-1:0]        out_b,
    output logic                 out_wr,
    output logic [(1<<AW)-1:0]   busy_vec,
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    output logic                 err,
`endif
    output logic                 halted
);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          halted_q, halted_d;
    logic          rd_en1_q, rd_en1_d;
    logic          rd_en2_q, rd_en2_d;
    logic [AW-1:0] rd_addr1_q, rd_addr1_d;
    logic [AW-1:0] rd_addr2_q, rd_addr2_d;
    logic          out_valid_q, out_valid_d;
    logic [3:0]    out_op_q, out_op_d;
    logic [AW-1:0] out_dst_q, out_dst_d;
    logic [DW-1:0] out_a_q, out_a_d;
    logic [DW-1:0] out_b_q, out_b_d;
    logic          out_wr_q, out_wr_d;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
    logic          err_q, err_d;
`endif

    logic          accept;
    logic          hazard;
    logic          stopped;
    logic [3:0]    in_op;
    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [5:0]    imm;
    logic          need1, need2;

    // Decode of the latched instruction
    assign in_op = in_instr[OP_MSB:OP_LSB];
    assign op    = instr_q[OP_MSB:OP_LSB];
    assign rd    = instr_q[RD_MSB:RD_LSB];
    assign rs1   = instr_q[RS1_MSB:RS1_LSB];
    assign rs2   = instr_q[RS2_MSB:RS2_LSB];
    assign imm   = instr_q[IMM_MSB:IMM_LSB];
    assign need1 = op_reads_rs1(op);
    assign need2 = op_reads_rs2(op);

`ifdef OPFETCH_ILLEGAL_TRAP_EN
    assign stopped = halted_q || err_q;
`else
    assign stopped = halted_q;
`endif

    assign in_ready = (state_q == ST_IDLE) && !stopped;
    assign accept   = in_valid && in_ready;

    // Scoreboard: set on a completed issue of a writing op, clear on writeback
    reg_scoreboard #(.AW(AW)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (out_valid_q && out_ready && out_wr_q),
        .set_addr (out_dst_q),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .rs1_addr (rs1),
        .rs1_need (need1),
        .rs2_addr (rs2),
        .rs2_need (need2),
        .hazard   (hazard),
        .busy_vec (busy_vec)
    );

    // Next-state and datapath control for the fetch FSM
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        halted_d    = halted_q;
        rd_en1_d    = rd_en1_q;
        rd_en2_d    = rd_en2_q;
        rd_addr1_d  = rd_addr1_q;
        rd_addr2_d  = rd_addr2_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_dst_d   = out_dst_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_wr_d    = out_wr_q;
`ifdef OPFETCH_ILLEGAL_TRAP_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = in_instr;
                    if (in_op == OP_HALT) begin
                        halted_d = 1'b1;
                    end else if (op_issues(in_op)) begin
                        state_d = ST_CHECK;
                    end else if (in_op != OP_NOP) begin
`ifdef OPFETCH_ILLEGAL_TRAP_EN
                        err_d = 1'b1;
`endif
                    end
                end
            end
            ST_CHECK: begin
                if (!hazard) begin
                    if (op == OP_LDI) begin
                        state_d     = ST_ISSUE;
                        out_valid_d = 1'b1;
                        out_op_d    = op;
                        out_dst_d   = rd;
                        out_wr_d    = 1'b1;
                        out_a_d     = '0;
                        out_b_d     = sext_imm6(imm);
                    end else begin
                        state_d    = ST_READ;
                        rd_en1_d   = need1;
                        rd_en2_d   = need2;
                        rd_addr1_d = need1 ? rs1 : '0;
                        rd_addr2_d = need2 ? rs2 : '0;
                    end
                end
            end
            ST_READ: begin
                state_d  = ST_CAPT;
                rd_en1_d = 1'b0;
                rd_en2_d = 1'b0;
            end
            ST_CAPT: begin
                state_d     = ST_ISSUE;
                out_valid_d = 1'b1;
                out_op_d    = op;
                out_dst_d   = rd;
                out_wr_d    = op_issues(op);
                out_a_d     = need1 ? rf_rd_data1 : '0;
                out_b_d     = need2 ? rf_rd_data2 : sext_imm6(imm);
            end
            ST_ISSUE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            halted_q    <= 1'b0;
            rd_en1_q    <= 1'b0;
            rd_en2_q    <= 1'b0;
            rd_addr1_q  <= '0;
            rd_addr2_q  <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_dst_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            halted_q    <= halted_d;
            rd_en1_q    <= rd_en1_d;
            rd_en2_q    <= rd_en2_d;
            rd_addr1_q  <= rd_addr1_d;
            rd_addr2_q  <= rd_addr2_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_dst_q   <= out_dst_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_wr_q    <= out_wr_d;
        end
    end

`ifdef OPFETCH_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`endif

    assign halted      = halted_q;
    assign rf_rd_en1   = rd_en1_q;
    assign rf_rd_en2   = rd_en2_q;
    assign rf_rd_addr1 = rd_addr1_q;
    assign rf_rd_addr2 = rd_addr2_q;
    assign out_valid   = out_valid_q;
    assign out_op      = out_op_q;
    assign out_dst     = out_dst_q;
    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign out_wr      = out_wr_q;

endmodule
